// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply unit and its EX-stage neighbours.
package hilo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } state_t;

  localparam logic [1:0] REGSEL_NONE = 2'b00;
  localparam logic [1:0] REGSEL_HI   = 2'b01;
  localparam logic [1:0] REGSEL_LO   = 2'b10;

  localparam logic [3:0] ALU_MULT  = 4'b0110;
  localparam logic [3:0] ALU_MULTU = 4'b0111;

  // 2'b11 is deliberately not a read, so only the two legal selects count.
  function automatic logic is_read(input logic [1:0] sel);
    return (sel == REGSEL_HI) || (sel == REGSEL_LO);
  endfunction

endpackage

// File: rtl/hilo_mult_unit_if.sv
// EX-stage bundle between the control path and the HI/LO multiply unit.
interface hilo_mult_unit_if #(
  parameter int WIDTH = 32
);

  logic             enhilo_EX;
  logic             signed_EX;
  logic [WIDTH-1:0] a_EX;
  logic [WIDTH-1:0] b_EX;
  logic [1:0]       regsel_EX;
  logic [WIDTH-1:0] hilo_out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output enhilo_EX, signed_EX, a_EX, b_EX, regsel_EX,
    input  hilo_out, hi, lo, busy, stall, done
  );

  modport slave (
    input  enhilo_EX, signed_EX, a_EX, b_EX, regsel_EX,
    output hilo_out, hi, lo, busy, stall, done
  );

endinterface

// File: rtl/hilo_mult_unit_shift_add_core.sv
// Radix-2 shift-add datapath on unsigned magnitudes: accumulator, multiplier shift register, counter.
module shift_add_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   partial;

  // Carry out of the add becomes the new accumulator MSB after the shift.
  always_comb begin
    partial = {1'b0, acc};
    if (mplier[0]) begin
      partial = {1'b0, acc} + {1'b0, mcand};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
      count  <= '0;
    end else if (init) begin
      acc    <= '0;
      mplier <= mplier_in;
      mcand  <= mcand_in;
      count  <= '0;
    end else if (step) begin
      {acc, mplier} <= {partial, mplier[WIDTH-1:1]};
      count         <= count + CNT_W'(1);
    end
  end

  assign product = {acc, mplier};
  assign last    = (count == LAST_ITER);

endmodule

// File: rtl/hilo_mult_unit.sv
// HI/LO multiply unit for the EX stage: iterative signed/unsigned multiply plus mfhi/mflo read port.
// Define HILO_FAST_MULT_EN to replace the iterative core with a single-cycle multiply.
module hilo_mult_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  hilo_mult_unit_if.slave bus
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  always_comb begin
    case (bus.regsel_EX)
      REGSEL_HI: bus.hilo_out = hi_q;
      REGSEL_LO: bus.hilo_out = lo_q;
      default:   bus.hilo_out = '0;
    endcase
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.done = done_q;

`ifdef HILO_FAST_MULT_EN

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] fast_product;

  // Sign- or zero-extending to 2*WIDTH makes one truncated multiply serve both mult and multu.
  always_comb begin
    ext_a        = {{WIDTH{bus.signed_EX & bus.a_EX[WIDTH-1]}}, bus.a_EX};
    ext_b        = {{WIDTH{bus.signed_EX & bus.b_EX[WIDTH-1]}}, bus.b_EX};
    fast_product = ext_a * ext_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= bus.enhilo_EX;
      if (bus.enhilo_EX) begin
        {hi_q, lo_q} <= fast_product;
      end
    end
  end

  assign bus.busy  = 1'b0;
  assign bus.stall = 1'b0;

`else

  state_t             state;
  logic               neg_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               core_init;
  logic               core_step;
  logic [2*WIDTH-1:0] core_product;
  logic               core_last;

  // The most negative value negates to itself, which is already its correct unsigned magnitude.
  always_comb begin
    mag_a = bus.a_EX;
    mag_b = bus.b_EX;
    if (bus.signed_EX && bus.a_EX[WIDTH-1]) begin
      mag_a = -bus.a_EX;
    end
    if (bus.signed_EX && bus.b_EX[WIDTH-1]) begin
      mag_b = -bus.b_EX;
    end
  end

  assign core_init = (state == IDLE) && bus.enhilo_EX;
  assign core_step = (state == RUN);

  shift_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .init      (core_init),
    .step      (core_step),
    .mcand_in  (mag_a),
    .mplier_in (mag_b),
    .product   (core_product),
    .last      (core_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enhilo_EX) begin
            neg_q <= bus.signed_EX & (bus.a_EX[WIDTH-1] ^ bus.b_EX[WIDTH-1]);
            state <= RUN;
          end
        end
        RUN: begin
          if (core_last) begin
            state  <= FINISH;
            done_q <= 1'b1;
          end
        end
        FINISH: begin
          {hi_q, lo_q} <= neg_q ? -core_product : core_product;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy && (bus.enhilo_EX || is_read(bus.regsel_EX));

`endif

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit (default iterative build) against a plain-arithmetic product model.
module tb_hilo_mult_unit;
  import hilo_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  hilo_mult_unit_if #(.WIDTH(WIDTH)) bus ();

  hilo_mult_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_product(input logic sgn, input logic [31:0] a,
                                              input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return sa * sb;
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and runs until the cycle results become visible (cycle 34).
  task automatic do_mult(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int done_cyc, output int done_cnt, output int busy_cyc);
    bus.enhilo_EX = 1'b1;
    bus.signed_EX = sgn;
    bus.a_EX      = a;
    bus.b_EX      = b;
    done_cyc = -1;
    done_cnt = 0;
    busy_cyc = 0;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (c == 1) begin
        bus.enhilo_EX = 1'b0;
        bus.signed_EX = ~sgn;
        bus.a_EX      = $urandom();
        bus.b_EX      = $urandom();
      end
      #1;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.busy === 1'b1) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.enhilo_EX = 1'b1;
    bus.signed_EX = 1'b0;
    bus.a_EX      = 32'h0000_1234;
    bus.b_EX      = 32'h0000_5678;
    bus.regsel_EX = REGSEL_HI;
    repeat (3) tick();
    vectors++;
    if (bus.hi !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_hi: got %h, expected %h", bus.hi, 32'h0);
    end
    vectors++;
    if (bus.lo !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_lo: got %h, expected %h", bus.lo, 32'h0);
    end
    vectors++;
    if ({bus.busy, bus.stall, bus.done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got busy/stall/done=%b, expected 000",
               {bus.busy, bus.stall, bus.done});
    end
    vectors++;
    if (bus.hilo_out !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_hilo_out: got %h, expected %h", bus.hilo_out, 32'h0);
    end
    bus.enhilo_EX = 1'b0;
    bus.regsel_EX = REGSEL_NONE;
    rst = 1'b1;
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release_busy: got %b, expected 0", bus.busy);
    end
  endtask

  task automatic test_unsigned();
    int dc, dn, bc;
    logic [63:0] exp;
    exp = ref_product(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, dn, bc);
    vectors++;
    if ({bus.hi, bus.lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL multu_max: got %h_%h, expected %h", bus.hi, bus.lo, exp);
    end
    vectors++;
    if (dc != 33 || dn != 1) begin
      miscompares++;
      $display("[TB] FAIL multu_done: got cycle %0d count %0d, expected cycle 33 count 1", dc, dn);
    end
    vectors++;
    if (bc != 33 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL multu_busy: got %0d busy cycles (busy now %b), expected 33 (0)", bc, bus.busy);
    end
  endtask

  task automatic test_signed();
    int dc, dn, bc;
    logic [63:0] exp;
    exp = ref_product(1'b1, 32'hFFFF_FFFD, 32'd5);
    do_mult(1'b1, 32'hFFFF_FFFD, 32'd5, dc, dn, bc);
    vectors++;
    if ({bus.hi, bus.lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL mult_neg3x5: got %h_%h, expected %h", bus.hi, bus.lo, exp);
    end
    exp = ref_product(1'b0, 32'hFFFF_FFFD, 32'd5);
    do_mult(1'b0, 32'hFFFF_FFFD, 32'd5, dc, dn, bc);
    vectors++;
    if ({bus.hi, bus.lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL multu_neg3x5: got %h_%h, expected %h", bus.hi, bus.lo, exp);
    end
  endtask

  task automatic test_corners();
    int dc, dn, bc;
    logic [63:0] exp;
    exp = ref_product(1'b1, 32'h8000_0000, 32'h8000_0000);
    do_mult(1'b1, 32'h8000_0000, 32'h8000_0000, dc, dn, bc);
    vectors++;
    if ({bus.hi, bus.lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL mult_minint_sq: got %h_%h, expected %h", bus.hi, bus.lo, exp);
    end
    exp = ref_product(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_mult(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, dn, bc);
    vectors++;
    if ({bus.hi, bus.lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL mult_neg1_sq: got %h_%h, expected %h", bus.hi, bus.lo, exp);
    end
    exp = ref_product(1'b1, 32'h0, 32'h8000_0001);
    do_mult(1'b1, 32'h0, 32'h8000_0001, dc, dn, bc);
    vectors++;
    if ({bus.hi, bus.lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL mult_zero_neg: got %h_%h, expected %h", bus.hi, bus.lo, exp);
    end
  endtask

  task automatic test_read_idle();
    int dc, dn, bc;
    logic [63:0] exp;
    logic [31:0] a, b, want;
    a = $urandom();
    b = $urandom();
    exp = ref_product(1'b1, a, b);
    do_mult(1'b1, a, b, dc, dn, bc);
    for (int s = 0; s < 4; s++) begin
      bus.regsel_EX = 2'(s);
      #1;
      want = (s == 1) ? exp[63:32] : (s == 2) ? exp[31:0] : 32'h0;
      vectors++;
      if (bus.hilo_out !== want || bus.stall !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_read_sel%0d: got %h stall %b, expected %h stall 0",
                 s, bus.hilo_out, bus.stall, want);
      end
    end
    bus.regsel_EX = REGSEL_NONE;
  endtask

  task automatic test_hazard();
    int stall_cnt;
    logic [63:0] exp;
    exp = ref_product(1'b1, 32'd7, 32'd9);
    bus.enhilo_EX = 1'b1;
    bus.signed_EX = 1'b1;
    bus.a_EX      = 32'd7;
    bus.b_EX      = 32'd9;
    stall_cnt     = 0;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (c == 1) begin
        bus.enhilo_EX = 1'b0;
        bus.regsel_EX = REGSEL_HI;
      end
      #1;
      if (c <= 33 && bus.stall === 1'b1) stall_cnt++;
    end
    vectors++;
    if (stall_cnt != 33 || bus.stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hazard_stall: got %0d stalled cycles (stall now %b), expected 33 (0)",
               stall_cnt, bus.stall);
    end
    vectors++;
    if (bus.hilo_out !== exp[63:32]) begin
      miscompares++;
      $display("[TB] FAIL hazard_mfhi: got %h, expected %h", bus.hilo_out, exp[63:32]);
    end
    bus.regsel_EX = REGSEL_LO;
    #1;
    vectors++;
    if (bus.hilo_out !== exp[31:0]) begin
      miscompares++;
      $display("[TB] FAIL hazard_mflo: got %h, expected %h", bus.hilo_out, exp[31:0]);
    end
    bus.regsel_EX = REGSEL_NONE;
  endtask

  task automatic test_busy_start();
    int stall_cnt, done_cnt;
    logic        sgn;
    logic [31:0] a1, b1;
    logic [63:0] exp;
    sgn = 1'($urandom_range(0, 1));
    a1  = $urandom();
    b1  = $urandom();
    exp = ref_product(sgn, a1, b1);
    bus.enhilo_EX = 1'b1;
    bus.signed_EX = sgn;
    bus.a_EX      = a1;
    bus.b_EX      = b1;
    stall_cnt = 0;
    done_cnt  = 0;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (c == 1) bus.enhilo_EX = 1'b0;
      if (c == 5) begin
        bus.enhilo_EX = 1'b1;
        bus.signed_EX = ~sgn;
        bus.a_EX      = a1 ^ 32'h5A5A_0001;
        bus.b_EX      = b1 ^ 32'h0F0F_8002;
      end
      if (c == 21) bus.enhilo_EX = 1'b0;
      #1;
      if (c >= 5 && c <= 20 && bus.stall === 1'b1) stall_cnt++;
      if (bus.done === 1'b1) done_cnt++;
    end
    vectors++;
    if (stall_cnt != 16) begin
      miscompares++;
      $display("[TB] FAIL busy_start_stall: got %0d stalled cycles, expected 16", stall_cnt);
    end
    vectors++;
    if ({bus.hi, bus.lo} !== exp || done_cnt != 1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_start_result: got %h_%h done %0d busy %b, expected %h done 1 busy 0",
               bus.hi, bus.lo, done_cnt, bus.busy, exp);
    end
  endtask

  task automatic test_back_to_back();
    int dc, dn, bc;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int k = 0; k < 2; k++) begin
      a   = $urandom();
      b   = $urandom();
      exp = ref_product(1'(k), a, b);
      do_mult(1'(k), a, b, dc, dn, bc);
      vectors++;
      if ({bus.hi, bus.lo} !== exp || dc != 33) begin
        miscompares++;
        $display("[TB] FAIL back_to_back_%0d: got %h_%h done cycle %0d, expected %h cycle 33",
                 k, bus.hi, bus.lo, dc, exp);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int dc, dn, bc, done_cnt, busy_cnt;
    logic [63:0] exp;
    exp = ref_product(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    do_mult(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, dc, dn, bc);
    vectors++;
    if ({bus.hi, bus.lo} !== exp) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_result: got %h_%h, expected %h", bus.hi, bus.lo, exp);
    end
    bus.enhilo_EX = 1'b1;
    bus.signed_EX = 1'b1;
    bus.a_EX      = 32'h7654_3210;
    bus.b_EX      = 32'h0BAD_F00D;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) bus.enhilo_EX = 1'b0;
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_run_reset: got hi %h lo %h busy %b done %b, expected 0 0 0 0",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    repeat (2) tick();
    rst = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 36; c++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    vectors++;
    if (done_cnt != 0 || busy_cnt != 0 || bus.lo !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_quiet: got done %0d busy %0d lo %h, expected 0 0 0",
               done_cnt, busy_cnt, bus.lo);
    end
    do_mult(1'b1, 32'd2, 32'd3, dc, dn, bc);
    vectors++;
    if (bus.lo !== 32'd6 || bus.hi !== 32'd0 || dc != 33) begin
      miscompares++;
      $display("[TB] FAIL post_reset_2x3: got hi %h lo %h done cycle %0d, expected 0 6 33",
               bus.hi, bus.lo, dc);
    end
  endtask

  task automatic test_random();
    int dc, dn, bc;
    logic        sgn;
    logic [31:0] a, b;
    logic [63:0] exp;
    logic [31:0] pool [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 10; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom();
      b   = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom();
      exp = ref_product(sgn, a, b);
      do_mult(sgn, a, b, dc, dn, bc);
      vectors++;
      if ({bus.hi, bus.lo} !== exp || dc != 33 || dn != 1) begin
        miscompares++;
        $display("[TB] FAIL random_%0d s=%0d a=%h b=%h: got %h_%h done %0d/%0d, expected %h 33/1",
                 i, sgn, a, b, bus.hi, bus.lo, dc, dn, exp);
      end
    end
  endtask

  initial begin
    rst           = 1'b0;
    bus.enhilo_EX = 1'b0;
    bus.signed_EX = 1'b0;
    bus.a_EX      = '0;
    bus.b_EX      = '0;
    bus.regsel_EX = REGSEL_NONE;
    test_reset();
    test_unsigned();
    test_signed();
    test_corners();
    test_read_idle();
    test_hazard();
    test_busy_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
